ret_pop_sequencer: RTL

//  Executes the return family (RET, RETI, RET cc) for the control unit: pops PC low/high bytes off the stack,

---
 rtl/ret_pop_sequencer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ret_pop_sequencer.sv
// Return-family microcode sequencer (RET, RETI, optional RET cc): pops PC lo/hi off the stack, paced by i_M_Tick.
// Conditional returns are built only when RET_SEQ_COND_EN is defined.
module ret_pop_sequencer #(
    parameter int ADDR_W = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_M_Tick,
    input  logic              i_Start,
    input  logic [7:0]        i_Opcode,
    input  logic              i_Flag_Z,
    input  logic              i_Flag_C,
    input  logic [ADDR_W-1:0] i_SP,
    input  logic [7:0]        i_Mem_Data,
    output logic              o_Mem_Rd,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [ADDR_W-1:0] o_SP,
    output logic              o_SP_Write,
    output logic [ADDR_W-1:0] o_PC,
    output logic              o_PC_Write,
    output logic              o_IME_Set,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP_LO = 3'd1,
        S_POP_HI = 3'd2,
        S_LOAD   = 3'd3
`ifdef RET_SEQ_COND_EN
        ,S_COND  = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_sp, w_sp_nxt;
    logic [7:0]        r_lo, w_lo_nxt;
    logic [7:0]        r_hi, w_hi_nxt;
    logic              r_reti, w_reti_nxt;
    logic              r_mem_rd, w_mem_rd_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_sp_write, w_sp_write_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_pc_write, w_pc_write_nxt;
    logic              r_ime_set, w_ime_set_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_illegal, w_illegal_nxt;
    logic              w_is_ret;

    assign w_is_ret = (i_Opcode == 8'hC9) || (i_Opcode == 8'hD9);

`ifdef RET_SEQ_COND_EN
    logic       r_flag_z, w_flag_z_nxt;
    logic       r_flag_c, w_flag_c_nxt;
    logic [1:0] r_cc, w_cc_nxt;
    logic       w_is_cc;
    logic       w_cond_true;

    // C0/C8/D0/D8 share 11xx_x000; bits 4:3 select NZ/Z/NC/C
    assign w_is_cc = (i_Opcode == 8'hC0) || (i_Opcode == 8'hC8) ||
                     (i_Opcode == 8'hD0) || (i_Opcode == 8'hD8);

    // Condition evaluation against the flags captured at start
    always_comb begin
        w_cond_true = 1'b0;
        case (r_cc)
            2'b00:   w_cond_true = ~r_flag_z;
            2'b01:   w_cond_true = r_flag_z;
            2'b10:   w_cond_true = ~r_flag_c;
            2'b11:   w_cond_true = r_flag_c;
            default: w_cond_true = 1'b0;
        endcase
    end
`else
    logic w_unused_flags;
    assign w_unused_flags = i_Flag_Z ^ i_Flag_C;
`endif

    // Next-state and next-output computation
    always_comb begin
        w_state_nxt    = r_state;
        w_sp_nxt       = r_sp;
        w_lo_nxt       = r_lo;
        w_hi_nxt       = r_hi;
        w_reti_nxt     = r_reti;
        w_pc_nxt       = r_pc;
        w_sp_write_nxt = 1'b0;
        w_pc_write_nxt = 1'b0;
        w_ime_set_nxt  = 1'b0;
        w_done_nxt     = 1'b0;
        w_illegal_nxt  = 1'b0;
`ifdef RET_SEQ_COND_EN
        w_flag_z_nxt   = r_flag_z;
        w_flag_c_nxt   = r_flag_c;
        w_cc_nxt       = r_cc;
`endif
        case (r_state)
            S_IDLE: begin
                // A tick coinciding with start is deliberately not consumed here
                if (i_Start && w_is_ret) begin
                    w_state_nxt = S_POP_LO;
                    w_sp_nxt    = i_SP;
                    w_reti_nxt  = (i_Opcode == 8'hD9);
`ifdef RET_SEQ_COND_EN
                end else if (i_Start && w_is_cc) begin
                    w_state_nxt  = S_COND;
                    w_sp_nxt     = i_SP;
                    w_reti_nxt   = 1'b0;
                    w_flag_z_nxt = i_Flag_Z;
                    w_flag_c_nxt = i_Flag_C;
                    w_cc_nxt     = i_Opcode[4:3];
`endif
                end else if (i_Start) begin
                    w_illegal_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef RET_SEQ_COND_EN
            S_COND: begin
                if (i_M_Tick && w_cond_true) begin
                    w_state_nxt = S_POP_LO;
                end else if (i_M_Tick) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_COND;
                end
            end
`endif
            S_POP_LO: begin
                if (i_M_Tick) begin
                    w_lo_nxt       = i_Mem_Data;
                    w_sp_nxt       = r_sp + SP_ONE;
                    w_sp_write_nxt = 1'b1;
                    w_state_nxt    = S_POP_HI;
                end else begin
                    w_state_nxt = S_POP_LO;
                end
            end
            S_POP_HI: begin
                if (i_M_Tick) begin
                    w_hi_nxt       = i_Mem_Data;
                    w_sp_nxt       = r_sp + SP_ONE;
                    w_sp_write_nxt = 1'b1;
                    w_state_nxt    = S_LOAD;
                end else begin
                    w_state_nxt = S_POP_HI;
                end
            end
            S_LOAD: begin
                if (i_M_Tick) begin
                    w_pc_nxt       = ADDR_W'({r_hi, r_lo});
                    w_pc_write_nxt = 1'b1;
                    w_ime_set_nxt  = r_reti;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Read strobe/address track the state being entered so they cover the whole read state
        w_mem_rd_nxt   = (w_state_nxt == S_POP_LO) || (w_state_nxt == S_POP_HI);
        w_mem_addr_nxt = w_mem_rd_nxt ? w_sp_nxt : ADDR_ZERO;
        w_busy_nxt     = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state    <= S_IDLE;
            r_sp       <= ADDR_ZERO;
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_reti     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= ADDR_ZERO;
            r_sp_write <= 1'b0;
            r_pc       <= ADDR_ZERO;
            r_pc_write <= 1'b0;
            r_ime_set  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
`ifdef RET_SEQ_COND_EN
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_cc       <= 2'b00;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_sp       <= w_sp_nxt;
            r_lo       <= w_lo_nxt;
            r_hi       <= w_hi_nxt;
            r_reti     <= w_reti_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_sp_write <= w_sp_write_nxt;
            r_pc       <= w_pc_nxt;
            r_pc_write <= w_pc_write_nxt;
            r_ime_set  <= w_ime_set_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_illegal  <= w_illegal_nxt;
`ifdef RET_SEQ_COND_EN
            r_flag_z   <= w_flag_z_nxt;
            r_flag_c   <= w_flag_c_nxt;
            r_cc       <= w_cc_nxt;
`endif
        end
    end

    assign o_Mem_Rd   = r_mem_rd;
    assign o_Mem_Addr = r_mem_addr;
    assign o_SP       = r_sp;
    assign o_SP_Write = r_sp_write;
    assign o_PC       = r_pc;
    assign o_PC_Write = r_pc_write;
    assign o_IME_Set  = r_ime_set;
    assign o_Busy     = r_busy;
    assign o_Done     = r_done;
    assign o_Illegal  = r_illegal;

endmodule
